// File: rtl/pc_tx_framer_pkg.sv
// Shared types and constants for the PC transmit framer.
// The trailer checksum flavour is selected by PC_TX_FRAMER_CRC_EN in the top module.
package pc_tx_framer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_PAY,
        ST_TRL,
        ST_SEND,
        ST_GUARD,
        ST_DRAIN,
        ST_DONE
    } state_t;

    // Which word is in flight through SEND/GUARD/DRAIN, so DRAIN knows where to go next.
    typedef enum logic [1:0] {
        PH_HDR,
        PH_PAY,
        PH_TRL
    } phase_t;

    localparam logic [7:0]  SYNC_DEFAULT = 8'hA5;
    localparam logic [31:0] CRC32_POLY   = 32'h04C1_1DB7;
    localparam logic [31:0] CRC32_INIT   = 32'hFFFF_FFFF;

    function automatic logic [31:0] pack_header(input logic [7:0]  sync,
                                                input logic [7:0]  seq,
                                                input logic [15:0] len);
        return {sync, seq, len};
    endfunction

endpackage

// File: rtl/pc_tx_framer_if.sv
// Handshake bundle between the framer, its DataRouter source and the PC transmit block.
interface pc_tx_framer_if;
    logic        i_start;
    logic [15:0] i_frame_len;
    logic [31:0] i_word_data;
    logic        i_word_valid;
    logic        o_word_ready;
    logic        i_tx_busy;
    logic [31:0] o_tx_word;
    logic        o_tx_word_wr;
    logic        o_busy;
    logic        o_len_err;
    logic [7:0]  o_seq;

    // master: the framer itself
    modport master (
        input  i_start, i_frame_len, i_word_data, i_word_valid, i_tx_busy,
        output o_word_ready, o_tx_word, o_tx_word_wr, o_busy, o_len_err, o_seq
    );

    // slave: the surrounding source/sink logic
    modport slave (
        output i_start, i_frame_len, i_word_data, i_word_valid, i_tx_busy,
        input  o_word_ready, o_tx_word, o_tx_word_wr, o_busy, o_len_err, o_seq
    );
endinterface

// File: rtl/pc_tx_framer_crc32.sv
// Combinational CRC-32 update (poly 0x04C11DB7, MSB-first) absorbing one 32-bit word.
module crc32_word_step
    import pc_tx_framer_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [31:0] data,
    output logic [31:0] crc_out
);

    logic [31:0] c;
    logic        fb;

    always_comb begin
        c  = crc_in;
        fb = 1'b0;
        for (int i = 31; i >= 0; i--) begin
            fb = c[31] ^ data[i];
            c  = {c[30:0], 1'b0} ^ (fb ? CRC32_POLY : 32'h0);
        end
        crc_out = c;
    end

endmodule

// File: rtl/pc_tx_framer.sv
// Frames DataRouter payload words (header, payload, trailer) for the PC transmit block.
// Define PC_TX_FRAMER_CRC_EN for a CRC-32 trailer; otherwise the trailer is a 32-bit sum.
//
// state    | meaning
// IDLE     | waiting for i_start, length checked here
// HDR      | load header word
// PAY      | accept one payload word from DataRouter
// TRL      | load trailer word
// SEND     | wait for transmit block idle, then strobe
// GUARD    | ignore i_tx_busy while downstream starts up
// DRAIN    | wait for transmit block idle before the next word
// DONE     | bump sequence number, back to IDLE
module pc_tx_framer
    import pc_tx_framer_pkg::*;
#(
    parameter int         MAX_LEN      = 255,
    parameter int         GUARD_CYCLES = 4,
    parameter logic [7:0] SYNC_BYTE    = SYNC_DEFAULT
) (
    input logic            i_clock,
    input logic            i_reset_n,
    pc_tx_framer_if.master bus
);

    localparam int             GW         = (GUARD_CYCLES < 1) ? 1 : $clog2(GUARD_CYCLES + 1);
    localparam logic [GW-1:0]  GUARD_LOAD = GW'(GUARD_CYCLES);

    state_t         state;
    phase_t         phase;
    logic [15:0]    pay_cnt;
    logic [GW-1:0]  guard_cnt;
    logic [31:0]    chk;
    logic [31:0]    chk_next;
    logic [31:0]    trailer;
    logic           len_ok;

`ifdef PC_TX_FRAMER_CRC_EN
    localparam logic [31:0] CHK_INIT = CRC32_INIT;

    crc32_word_step u_crc (
        .crc_in  (chk),
        .data    (bus.i_word_data),
        .crc_out (chk_next)
    );
    assign trailer = ~chk;
`else
    localparam logic [31:0] CHK_INIT = 32'h0;

    assign chk_next = chk + bus.i_word_data;
    assign trailer  = chk;
`endif

    assign len_ok = (bus.i_frame_len != 16'd0) && (32'(bus.i_frame_len) <= 32'(MAX_LEN));

    // Same-cycle accept: the word taken here is the one loaded into o_tx_word.
    assign bus.o_word_ready = (state == ST_PAY) && bus.i_word_valid;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state            <= ST_IDLE;
            phase            <= PH_HDR;
            pay_cnt          <= '0;
            guard_cnt        <= '0;
            chk              <= '0;
            bus.o_tx_word    <= '0;
            bus.o_tx_word_wr <= 1'b0;
            bus.o_busy       <= 1'b0;
            bus.o_len_err    <= 1'b0;
            bus.o_seq        <= '0;
        end else begin
            bus.o_tx_word_wr <= 1'b0;
            bus.o_len_err    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.i_start) begin
                        if (len_ok) begin
                            pay_cnt    <= bus.i_frame_len;
                            chk        <= CHK_INIT;
                            bus.o_busy <= 1'b1;
                            state      <= ST_HDR;
                        end else begin
                            bus.o_len_err <= 1'b1;
                        end
                    end
                end
                ST_HDR: begin
                    bus.o_tx_word <= pack_header(SYNC_BYTE, bus.o_seq, pay_cnt);
                    phase         <= PH_HDR;
                    state         <= ST_SEND;
                end
                ST_PAY: begin
                    if (bus.i_word_valid) begin
                        bus.o_tx_word <= bus.i_word_data;
                        chk           <= chk_next;
                        pay_cnt       <= pay_cnt - 16'd1;
                        phase         <= PH_PAY;
                        state         <= ST_SEND;
                    end
                end
                ST_TRL: begin
                    bus.o_tx_word <= trailer;
                    phase         <= PH_TRL;
                    state         <= ST_SEND;
                end
                ST_SEND: begin
                    if (!bus.i_tx_busy) begin
                        bus.o_tx_word_wr <= 1'b1;
                        guard_cnt        <= GUARD_LOAD;
                        state            <= ST_GUARD;
                    end
                end
                ST_GUARD: begin
                    if (guard_cnt <= GW'(1)) begin
                        state <= ST_DRAIN;
                    end else begin
                        guard_cnt <= guard_cnt - GW'(1);
                    end
                end
                ST_DRAIN: begin
                    if (!bus.i_tx_busy) begin
                        case (phase)
                            PH_HDR:  state <= ST_PAY;
                            PH_PAY:  state <= (pay_cnt == 16'd0) ? ST_TRL : ST_PAY;
                            default: state <= ST_DONE;
                        endcase
                    end
                end
                ST_DONE: begin
                    bus.o_seq  <= bus.o_seq + 8'd1;
                    bus.o_busy <= 1'b0;
                    state      <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_tx_framer.sv
// Scoreboard bench for pc_tx_framer (default sum-trailer build).
module tb_pc_tx_framer;
    import pc_tx_framer_pkg::*;

    logic clk;
    logic rst_n;

    pc_tx_framer_if bus ();

    pc_tx_framer dut (
        .i_clock   (clk),
        .i_reset_n (rst_n),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    int          strobe_cnt = 0;
    logic [31:0] exp_q[$];
    logic [31:0] pay_q[$];
    logic [31:0] stim[8];
    logic [7:0]  model_seq = 8'd0;
    logic        took = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %08h, expected %08h", name, act, exp);
        end
    endtask

    // Monitor: every strobe is compared against the next expected word.
    always @(negedge clk) begin
        if (rst_n && bus.o_tx_word_wr) begin
            strobe_cnt++;
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_strobe: got %08h, expected no strobe", bus.o_tx_word);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (bus.o_tx_word !== e) begin
                    fails++;
                    $display("FAIL tx_word: got %08h, expected %08h", bus.o_tx_word, e);
                end
            end
        end
    end

    // Payload source: presents pay_q head; pops once the framer has taken it.
    always @(negedge clk) begin
        if (took) begin
            if (pay_q.size() > 0) void'(pay_q.pop_front());
            took = 1'b0;
        end
        if (pay_q.size() > 0) begin
            bus.i_word_valid = 1'b1;
            bus.i_word_data  = pay_q[0];
        end else begin
            bus.i_word_valid = 1'b0;
        end
        #1 took = bus.i_word_valid && bus.o_word_ready;
    end

    task automatic pulse_start(input logic [15:0] len);
        @(negedge clk);
        bus.i_start     = 1'b1;
        bus.i_frame_len = len;
        @(negedge clk);
        bus.i_start     = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        bit done = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (!bus.o_busy) begin
                done = 1;
                break;
            end
        end
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: got busy after 3000 cycles, expected idle", name);
        end
    endtask

    task automatic run_frame(input int len, input bit wait_done);
        logic [31:0] sum = 32'h0;
        exp_q.push_back({8'hA5, model_seq, 16'(len)});
        for (int i = 0; i < len; i++) begin
            pay_q.push_back(stim[i]);
            exp_q.push_back(stim[i]);
            sum = sum + stim[i];
        end
        exp_q.push_back(sum);
        pulse_start(16'(len));
        check("busy_after_start", 32'(bus.o_busy), 32'd1);
        if (wait_done) begin
            wait_idle("frame");
            model_seq = model_seq + 8'd1;
            check("o_seq", 32'(bus.o_seq), 32'(model_seq));
        end
    endtask

    initial begin
        logic [31:0] held;
        bit          ok;
        bit          seen;
        int          n0;

        rst_n            = 1'b0;
        bus.i_start      = 1'b0;
        bus.i_frame_len  = '0;
        bus.i_word_data  = '0;
        bus.i_word_valid = 1'b0;
        bus.i_tx_busy    = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tx_word", bus.o_tx_word, 32'h0);
        check("rst_wr",      32'(bus.o_tx_word_wr), 32'h0);
        check("rst_busy",    32'(bus.o_busy), 32'h0);
        check("rst_len_err", 32'(bus.o_len_err), 32'h0);
        check("rst_seq",     32'(bus.o_seq), 32'h0);
        check("rst_ready",   32'(bus.o_word_ready), 32'h0);
        rst_n = 1'b1;

        // Basic frame: expect A5000002, 1, 2, 3 and seq 1.
        stim[0] = 32'h1;
        stim[1] = 32'h2;
        run_frame(2, 1);

        // Illegal lengths.
        foreach (stim[i]) stim[i] = 32'h0;
        pulse_start(16'd0);
        check("len0_err", 32'(bus.o_len_err), 32'd1);
        check("len0_busy", 32'(bus.o_busy), 32'd0);
        @(negedge clk);
        check("len0_err_clear", 32'(bus.o_len_err), 32'd0);
        pulse_start(16'd256);
        check("len256_err", 32'(bus.o_len_err), 32'd1);
        check("len256_busy", 32'(bus.o_busy), 32'd0);
        @(negedge clk);
        check("len256_err_clear", 32'(bus.o_len_err), 32'd0);

        // Downstream busy for 100 cycles after the header strobe.
        stim[0] = 32'h1234_5678;
        run_frame(1, 0);
        seen = 0;
        for (int c = 0; c < 50; c++) begin
            if (bus.o_tx_word_wr) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        check("busy_hdr_strobe_seen", 32'(seen), 32'd1);
        bus.i_tx_busy = 1'b1;
        held = bus.o_tx_word;
        ok   = 1;
        repeat (100) begin
            @(negedge clk);
            if (bus.o_tx_word_wr || bus.o_tx_word !== held) ok = 0;
        end
        check("busy_hold_stable", 32'(ok), 32'd1);
        bus.i_tx_busy = 1'b0;
        wait_idle("busy");
        model_seq = model_seq + 8'd1;
        check("busy_seq", 32'(bus.o_seq), 32'(model_seq));

        // Sum wraps modulo 2^32: trailer 1.
        stim[0] = 32'hFFFF_FFFF;
        stim[1] = 32'h0000_0002;
        run_frame(2, 1);

        // Reset after 3 payload words of a 5-word frame.
        for (int i = 0; i < 5; i++) stim[i] = 32'h100 + 32'(i);
        n0 = strobe_cnt;
        run_frame(5, 0);
        for (int c = 0; c < 500 && strobe_cnt < n0 + 4; c++) @(negedge clk);
        check("midreset_strobes", 32'(strobe_cnt - n0), 32'd4);
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        check("midreset_tx_word", bus.o_tx_word, 32'h0);
        check("midreset_wr",      32'(bus.o_tx_word_wr), 32'h0);
        check("midreset_busy",    32'(bus.o_busy), 32'h0);
        check("midreset_seq",     32'(bus.o_seq), 32'h0);
        check("midreset_ready",   32'(bus.o_word_ready), 32'h0);
        exp_q.delete();
        pay_q.delete();
        took = 1'b0;
        model_seq = 8'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // 257 single-word frames: header seq runs 00..FF then wraps to 00.
        for (int f = 0; f < 257; f++) begin
            stim[0] = 32'(f * 3 + 1);
            run_frame(1, 1);
        end
        check("wrap_final_seq", 32'(bus.o_seq), 32'd1);

        repeat (5) @(negedge clk);
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        check("pay_q_drained", 32'(pay_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
